// File: rtl/bmem_pkg.sv
// ============================================================================
// bmem_pkg : shared constants and FSM state type for the burst responder
// Revision : 1.0
// ============================================================================
`default_nettype none

package bmem_pkg;
  localparam int BEATS  = 4;
  localparam int LINE_W = 256;
  localparam int BEAT_W = LINE_W / BEATS;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_BURST = 3'd2,
    WR_BURST = 3'd3,
    WR_WAIT  = 3'd4,
    WR_RESP  = 3'd5
  } bmem_state_e;
endpackage

`default_nettype wire

// File: rtl/bmem_line_store.sv
// ============================================================================
// bmem_line_store : 2^IDX_W x 256-bit line array, 1-cycle write, async read
// Revision : 1.0
// ============================================================================
`default_nettype none

module bmem_line_store
  import bmem_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wr_line,
  output logic [LINE_W-1:0] rd_line
);

  // Deliberately not reset: contents survive rst.
  logic [LINE_W-1:0] r_mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) r_mem[idx] <= wr_line;
  end

  assign rd_line = r_mem[idx];

endmodule

`default_nettype wire

// File: rtl/burst_mem_responder.sv
// ============================================================================
// burst_mem_responder : 4-beat burst memory responder with fixed latency
// Optional protocol checker enabled by BMEM_PROTOCOL_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module burst_mem_responder
  import bmem_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int LINE_IDX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_address,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic [63:0] bmem_rdata,
  output logic        bmem_resp,
  output logic        err
);

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  bmem_state_e             r_state, w_state_nxt;
  logic [3:0]              r_lat, w_lat_nxt;
  logic [1:0]              r_beat, w_beat_nxt;
  logic [LINE_IDX_W-1:0]   r_idx;
  logic [3*BEAT_W-1:0]     r_wbuf;
  logic [LINE_W-1:0]       w_rd_line;
  logic                    w_store_we;

  wire w_unused_addr = ^{bmem_address[31:LINE_IDX_W+5], bmem_address[4:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat;
    w_beat_nxt  = r_beat;
    w_store_we  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bmem_write) begin
          w_state_nxt = WR_BURST;
          w_beat_nxt  = 2'd1;
        end else if (bmem_read) begin
          w_state_nxt = RD_WAIT;
          w_lat_nxt   = LAT_LOAD;
          w_beat_nxt  = 2'd0;
        end
      end
      RD_WAIT: begin
        if (r_lat == 4'd0) w_state_nxt = RD_BURST;
        else               w_lat_nxt   = r_lat - 4'd1;
      end
      RD_BURST: begin
        w_beat_nxt = r_beat + 2'd1;
        if (r_beat == 2'd3) w_state_nxt = IDLE;
      end
      WR_BURST: begin
        w_beat_nxt = r_beat + 2'd1;
        if (r_beat == 2'd3) begin
          // Final beat goes straight to the store alongside the buffered three.
          w_store_we  = !rst;
          w_state_nxt = WR_WAIT;
          w_lat_nxt   = LAT_LOAD;
        end
      end
      WR_WAIT: begin
        if (r_lat == 4'd0) w_state_nxt = WR_RESP;
        else               w_lat_nxt   = r_lat - 4'd1;
      end
      WR_RESP: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_lat   <= 4'd0;
      r_beat  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_lat   <= w_lat_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == IDLE && (bmem_write || bmem_read))
        r_idx <= bmem_address[LINE_IDX_W+4:5];
      if (r_state == IDLE && bmem_write)
        r_wbuf[BEAT_W-1:0] <= bmem_wdata;
      if (r_state == WR_BURST && r_beat == 2'd1)
        r_wbuf[2*BEAT_W-1:BEAT_W] <= bmem_wdata;
      if (r_state == WR_BURST && r_beat == 2'd2)
        r_wbuf[3*BEAT_W-1:2*BEAT_W] <= bmem_wdata;
    end
  end

  bmem_line_store #(.IDX_W(LINE_IDX_W)) u_store (
    .clk     (clk),
    .we      (w_store_we),
    .idx     (r_idx),
    .wr_line ({bmem_wdata, r_wbuf}),
    .rd_line (w_rd_line)
  );

  assign bmem_resp  = (r_state == RD_BURST) || (r_state == WR_RESP);
  assign bmem_rdata = (r_state == RD_BURST) ? w_rd_line[{r_beat, 6'd0} +: BEAT_W] : '0;

`ifdef BMEM_PROTOCOL_CHECK_EN
  logic r_err;
  logic w_viol;

  always_comb begin
    w_viol = ((r_state == IDLE) && bmem_read && bmem_write)
          || ((r_state == WR_BURST) && !bmem_write)
          || (((r_state == WR_WAIT) || (r_state == WR_RESP)) && bmem_write)
          || ((r_state == RD_BURST) && bmem_read);
  end

  always_ff @(posedge clk) begin
    if (rst)         r_err <= 1'b0;
    else if (w_viol) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_burst_mem_responder.sv
// ============================================================================
// tb_burst_mem_responder : randomized self-checking bench with a line-array model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_burst_mem_responder;
  localparam int LAT = 4;

`ifdef BMEM_PROTOCOL_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bmem_address;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic [63:0] bmem_rdata;
  logic        bmem_resp;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [255:0] ref_line [256];
  bit           ref_valid [256];

  always #5 clk = ~clk;

  burst_mem_responder #(.LATENCY(LAT), .LINE_IDX_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bmem_address (bmem_address),
    .bmem_read    (bmem_read),
    .bmem_write   (bmem_write),
    .bmem_wdata   (bmem_wdata),
    .bmem_rdata   (bmem_rdata),
    .bmem_resp    (bmem_resp),
    .err          (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_addr(input int idx);
    logic [31:0] a;
    a = $urandom;
    a[12:5] = idx[7:0];
    return a;
  endfunction

  function automatic logic [255:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Caller sits in an IDLE cycle; accept happens at the next edge.
  // Returns positioned in the IDLE cycle right after the resp cycle.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input string tag);
    logic [63:0] beat;
    bmem_write   = 1'b1;
    bmem_address = addr;
    bmem_wdata   = line[63:0];
    for (int k = 1; k < 4; k++) begin
      tick;
      bmem_read    = 1'b0;
      bmem_address = $urandom;
      beat         = line[64*k +: 64];
      bmem_wdata   = beat;
      checks++;
      if (bmem_resp !== 1'b0) begin
        errors++;
        $display("FAIL %s beat%0d: resp=%0b expected 0", tag, k, bmem_resp);
      end
    end
    tick;
    bmem_write = 1'b0;
    bmem_wdata = {$urandom, $urandom};
    ref_line[addr[12:5]]  = line;
    ref_valid[addr[12:5]] = 1'b1;
    for (int j = 1; j <= LAT + 1; j++) begin
      tick;
      checks++;
      if (bmem_resp !== (j == LAT) || (j != LAT && bmem_rdata !== 64'd0)) begin
        errors++;
        $display("FAIL %s wait%0d: resp=%0b rdata=%h expected resp=%0b", tag, j, bmem_resp,
                 bmem_rdata, (j == LAT));
      end
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [255:0] exp, input string tag);
    logic        er;
    logic [63:0] ed;
    bmem_read    = 1'b1;
    bmem_address = addr;
    for (int j = 0; j <= LAT + 4; j++) begin
      tick;
      if (j == 0) begin
        bmem_read    = 1'b0;
        bmem_address = $urandom;
      end
      er = (j >= LAT) && (j <= LAT + 3);
      ed = 64'd0;
      if (er) ed = exp[64*(j-LAT) +: 64];
      checks++;
      if (bmem_resp !== er || bmem_rdata !== ed) begin
        errors++;
        $display("FAIL %s cyc%0d: resp=%0b rdata=%h expected resp=%0b rdata=%h", tag, j,
                 bmem_resp, bmem_rdata, er, ed);
      end
    end
  endtask

  task automatic pulse_reset;
    rst        = 1'b1;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    bmem_address = '0;
    bmem_wdata   = '0;
    pulse_reset();
    checks++;
    if (bmem_resp !== 1'b0 || bmem_rdata !== 64'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: resp=%0b rdata=%h err=%0b expected 0/0/0", bmem_resp, bmem_rdata, err);
    end
  endtask

  task automatic test_basic;
    logic [255:0] l;
    l = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    do_write(32'h0000_0040, l, "write_0x40");
    do_read(32'h0000_0040, l, "read_0x40");
  endtask

  task automatic test_simultaneous;
    logic [255:0] l;
    l = rand_line();
    bmem_read = 1'b1;
    do_write(32'h0000_0080, l, "simul_write");
    checks++;
    if (err !== CHK) begin
      errors++;
      $display("FAIL simul_err: err=%0b expected %0b", err, CHK);
    end
    do_read(32'h0000_0080, l, "simul_read");
    pulse_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL simul_err_clear: err=%0b expected 0", err);
    end
  endtask

  task automatic test_reset_mid;
    logic [255:0] l;
    l = ref_line[2];
    bmem_read    = 1'b1;
    bmem_address = 32'h0000_0040;
    tick;
    bmem_read = 1'b0;
    for (int j = 1; j <= LAT + 1; j++) tick;
    checks++;
    if (bmem_resp !== 1'b1 || bmem_rdata !== l[127:64]) begin
      errors++;
      $display("FAIL rst_mid_beat1: resp=%0b rdata=%h expected 1/%h", bmem_resp, bmem_rdata, l[127:64]);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int j = 0; j < LAT + 5; j++) begin
      checks++;
      if (bmem_resp !== 1'b0 || bmem_rdata !== 64'd0) begin
        errors++;
        $display("FAIL rst_mid_quiet%0d: resp=%0b rdata=%h expected 0/0", j, bmem_resp, bmem_rdata);
      end
      tick;
    end
    do_read(32'h0000_0040, l, "read_after_rst");
    // Abandon a write before its commit beat; the line must not change.
    bmem_write   = 1'b1;
    bmem_address = 32'h0000_0040;
    bmem_wdata   = {$urandom, $urandom};
    tick;
    bmem_wdata = {$urandom, $urandom};
    tick;
    bmem_wdata = {$urandom, $urandom};
    rst = 1'b1;
    tick;
    rst        = 1'b0;
    bmem_write = 1'b0;
    for (int j = 0; j < LAT + 5; j++) begin
      tick;
      checks++;
      if (bmem_resp !== 1'b0) begin
        errors++;
        $display("FAIL rst_wr_quiet%0d: resp=%0b expected 0", j, bmem_resp);
      end
    end
    do_read(32'h0000_0040, l, "read_after_wr_abort");
  endtask

  task automatic test_back_to_back;
    logic [255:0] l;
    l = rand_line();
    do_write(32'h0000_1FE0, l, "b2b_write_255");
    do_read(32'h0000_1FE0, l, "b2b_read_255");
    do_read(32'h0000_0040, ref_line[2], "b2b_read_again");
  endtask

  task automatic test_write_drop;
    bmem_write   = 1'b1;
    bmem_address = 32'h0000_0060;
    bmem_wdata   = {$urandom, $urandom};
    tick;
    bmem_wdata = {$urandom, $urandom};
    tick;
    bmem_write = 1'b0;
    for (int j = 0; j < LAT + 8; j++) begin
      tick;
      checks++;
      if (err !== CHK) begin
        errors++;
        $display("FAIL wr_drop_err%0d: err=%0b expected %0b", j, err, CHK);
      end
    end
    ref_valid[3] = 1'b0;
    pulse_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL wr_drop_clear: err=%0b expected 0", err);
    end
  endtask

  task automatic test_random;
    int idx;
    for (int n = 0; n < 24; n++) begin
      idx = $urandom_range(0, 8);
      if (idx == 8) idx = 255;
      if (!ref_valid[idx] || $urandom_range(0, 1) == 1)
        do_write(mk_addr(idx), rand_line(), "rand_write");
      else
        do_read(mk_addr(idx), ref_line[idx], "rand_read");
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rand_err: err=%0b expected 0", err);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bmem_read    = 1'b0;
    bmem_write   = 1'b0;
    bmem_address = '0;
    bmem_wdata   = '0;
    for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
    test_reset();
    test_basic();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    test_write_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/burst_mem_responder.md
BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from the accepting edge to the first response (legal range 1..15).
REQ-002 SHALL have parameter LINE_IDX_W, default 8, meaning the number of address bits indexing the line store (2^LINE_IDX_W lines of 256 bits).
REQ-003 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port bmem_address  input  32  line address; bits [4:0] are ignored.
REQ-006 SHALL have port bmem_read  input  1  read request.
REQ-007 SHALL have port bmem_write  input  1  write request, held high for the 4 data beats.
REQ-008 SHALL have port bmem_wdata  input  64  write beat.
REQ-009 SHALL have port bmem_rdata  output  64  read beat.
REQ-010 SHALL have port bmem_resp  output  1  response strobe.
REQ-011 SHALL have port err  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-012 SHALL use a one-hot or enumerated FSM with states IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT and WR_RESP.
REQ-013 SHALL index the line store by bmem_address[LINE_IDX_W+4:5].
REQ-014 SHALL, in IDLE, accept bmem_write at edge T: latch the index, capture the beat-0 wdata into bits [63:0], and go to WR_BURST.
REQ-015 SHALL capture beats 1..3 in WR_BURST at T+1..T+3 into bits [127:64], [191:128] and [255:192], and commit the full line to the store at T+3.
REQ-016 SHALL assert bmem_resp for exactly one cycle, in the cycle following edge T+3+LATENCY (via WR_WAIT and WR_RESP), then return to IDLE.
REQ-017 SHALL, in IDLE with bmem_write low, accept bmem_read at edge T: latch the index and go to RD_WAIT.
REQ-018 SHALL drive read beats k=0..3 on bmem_rdata with bmem_resp=1 in the four consecutive cycles following edges T+LATENCY+k.
- Beat k is line bits [64k+63:64k].
- After beat 3 the FSM returns to IDLE.
REQ-019 SHALL give write priority when bmem_read and bmem_write are both high in IDLE.
REQ-020 SHALL ignore bmem_read outside IDLE, so the requester may drop it after the accept cycle.
REQ-021 SHALL ignore bmem_address after the accept edge.
REQ-022 SHALL use a 4-bit latency counter and a 2-bit beat counter; the beat counter wraps 3->0 at the burst end.
REQ-023 SHALL accept a new request in the cycle immediately after the final resp, giving zero idle-cycle turnaround.
REQ-024 SHALL, for a read that follows a write to the same index, return the newly written data.
REQ-025 SHALL drive bmem_rdata to 0 whenever bmem_resp is 0.

Reset
REQ-026 SHALL, on rst, force the FSM to IDLE, bmem_resp=0, bmem_rdata=0, err=0, and clear both counters.
REQ-027 SHALL, on rst asserted mid-burst, abandon the transaction, leave the store unchanged, and produce no further resp.
REQ-028 SHALL NOT clear the line store on reset; a line is undefined until written.

Configuration
REQ-029 SHALL, with BMEM_PROTOCOL_CHECK_EN defined, set err sticky-high on any of the following:
- read and write both high in IDLE;
- bmem_write dropping before beat 3;
- bmem_write high in WR_WAIT or WR_RESP;
- bmem_read high while in RD_BURST.
REQ-030 SHALL, without BMEM_PROTOCOL_CHECK_EN, tie err to 0 and include no check logic.

Structure
REQ-031 SHALL place the FSM state enum, the BEATS=4 constant and the LINE_W=256 constant in the shared package bmem_pkg.
REQ-032 SHALL implement the line store as the single sub-module bmem_line_store, with a 1-cycle write and a combinational read by index.

Verification
REQ-033 SHALL cover this write case with LATENCY=4: write to 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33 and 0x44..44 at T..T+3 -> resp high only in the cycle after edge T+7.
REQ-034 SHALL cover this read case: read of 0x0000_0040 accepted at edge U -> resp high in the cycles after edges U+4..U+7, with rdata 0x11..11, 0x22..22, 0x33..33, 0x44..44 in order.
REQ-035 SHALL cover simultaneous read and write in IDLE to 0x80 -> the write is serviced, and err=1 only if the macro is defined.
REQ-036 SHALL cover rst asserted at read beat 1 -> resp=0 and rdata=0 from the next cycle, and a following read returns the unchanged line.
REQ-037 SHALL cover a back-to-back read issued the cycle after a write resp, at a wrapping index 0x1FE0 (index 255) -> accepted immediately with the correct data.
REQ-038 SHALL cover bmem_write dropped after beat 1 with the macro defined -> err=1 and held until rst.
